register_file_mp: RTL and testbench

//  Parametrised multi-port general-purpose register file for the core datapath. Generalises
//  the single-write register file with:
//  - N combinational read ports and two write ports.
//  - Optional hardwired zero register.
//  - Optional write-to-read bypass.
//  - Per-register busy scoreboard for hazard detection.
//  - A sequenced clear after reset.

---
 rtl/register_file_mp.sv | 111 +++++++++++
 tb/tb_register_file_mp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port general-purpose register file: N combinational read ports, two write ports,
// optional zero register and write bypass, busy scoreboard, and a sequenced clear after reset.
module register_file_mp #(
  parameter int DataLength   = 64,
  parameter int NumRegs      = 64,
  parameter int AddrWidth    = $clog2(NumRegs),
  parameter int NumReadPorts = 2,
  parameter int ZeroReg      = 1,
  parameter int Bypass       = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NumReadPorts*AddrWidth-1:0]  readreg_addr,
  output logic [NumReadPorts*DataLength-1:0] read_data,
  input  logic [AddrWidth-1:0]               writereg_addr0,
  input  logic [DataLength-1:0]              write_data0,
  input  logic                               RegWrite0,
  input  logic [AddrWidth-1:0]               writereg_addr1,
  input  logic [DataLength-1:0]              write_data1,
  input  logic                               RegWrite1,
  input  logic                               busy_set,
  input  logic [AddrWidth-1:0]               busy_addr,
  output logic [NumRegs-1:0]                 busy_vec,
  output logic                               ready
);

  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t                state_r;
  logic [AddrWidth-1:0]  clr_cnt_r;
  logic [DataLength-1:0] regs_r [NumRegs];
  logic [NumRegs-1:0]    busy_nxt_s;
  logic                  wr0_en_s;
  logic                  wr1_en_s;

  // Address 0 swallows writes when it is the hardwired zero register.
  assign wr0_en_s = RegWrite0 && !((ZeroReg != 0) && (writereg_addr0 == {AddrWidth{1'b0}}));
  assign wr1_en_s = RegWrite1 && !((ZeroReg != 0) && (writereg_addr1 == {AddrWidth{1'b0}}));

  // Scoreboard next state: writes retire producers, busy_set wins over a same-cycle retire.
  always_comb begin
    busy_nxt_s                 = busy_vec;
    busy_nxt_s[writereg_addr0] = busy_nxt_s[writereg_addr0] & ~RegWrite0;
    busy_nxt_s[writereg_addr1] = busy_nxt_s[writereg_addr1] & ~RegWrite1;
    busy_nxt_s[busy_addr]      = busy_nxt_s[busy_addr] | busy_set;
    busy_nxt_s[0]              = (ZeroReg != 0) ? 1'b0 : busy_nxt_s[0];
  end

  // Control FSM: sequenced clear after reset, then scoreboard tracking in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= CLEAR;
      clr_cnt_r <= {AddrWidth{1'b0}};
      busy_vec  <= {NumRegs{1'b0}};
      ready     <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          busy_vec  <= {NumRegs{1'b0}};
          clr_cnt_r <= clr_cnt_r + AddrWidth'(1);
          if (clr_cnt_r == AddrWidth'(NumRegs - 1)) begin
            state_r <= RUN;
            ready   <= 1'b1;
          end
        end
        RUN: begin
          busy_vec <= busy_nxt_s;
        end
        default: begin
          state_r   <= CLEAR;
          clr_cnt_r <= {AddrWidth{1'b0}};
          busy_vec  <= {NumRegs{1'b0}};
          ready     <= 1'b0;
        end
      endcase
    end
  end

  // Storage: one register zeroed per clear cycle; port 1 is written last so it wins collisions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == RUN) begin
        if (wr0_en_s) regs_r[writereg_addr0] <= write_data0;
        if (wr1_en_s) regs_r[writereg_addr1] <= write_data1;
      end else begin
        regs_r[clr_cnt_r] <= {DataLength{1'b0}};
      end
    end
  end

  // Read ports: zero register first, then bypass (port 1 over port 0), then storage.
  always_comb begin
    read_data = {(NumReadPorts*DataLength){1'b0}};
    for (int i = 0; i < NumReadPorts; i++) begin
      if (!ready) begin
        read_data[i*DataLength +: DataLength] = {DataLength{1'b0}};
      end else if ((ZeroReg != 0) && (readreg_addr[i*AddrWidth +: AddrWidth] == {AddrWidth{1'b0}})) begin
        read_data[i*DataLength +: DataLength] = {DataLength{1'b0}};
      end else if ((Bypass != 0) && RegWrite1 &&
                   (writereg_addr1 == readreg_addr[i*AddrWidth +: AddrWidth])) begin
        read_data[i*DataLength +: DataLength] = write_data1;
      end else if ((Bypass != 0) && RegWrite0 &&
                   (writereg_addr0 == readreg_addr[i*AddrWidth +: AddrWidth])) begin
        read_data[i*DataLength +: DataLength] = write_data0;
      end else begin
        read_data[i*DataLength +: DataLength] = regs_r[readreg_addr[i*AddrWidth +: AddrWidth]];
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: two instances (zero-reg+bypass, plain) driven with shared
// directed and random stimulus, compared against an array-based reference model.
module tb_register_file_mp;
  localparam int DL = 64;
  localparam int NR = 64;
  localparam int AW = 6;
  localparam int NP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NP*AW-1:0]  raddr;
  logic [AW-1:0]     wa0, wa1, ba;
  logic [DL-1:0]     wd0, wd1;
  logic              we0, we1, bs;
  logic [NP*DL-1:0]  rd_a, rd_b;
  logic [NR-1:0]     bv_a, bv_b;
  logic              rdy_a, rdy_b;

  register_file_mp #(.DataLength(DL), .NumRegs(NR), .AddrWidth(AW), .NumReadPorts(NP),
                     .ZeroReg(1), .Bypass(1)) dut_a (
    .clk(clk), .rst(rst), .readreg_addr(raddr), .read_data(rd_a),
    .writereg_addr0(wa0), .write_data0(wd0), .RegWrite0(we0),
    .writereg_addr1(wa1), .write_data1(wd1), .RegWrite1(we1),
    .busy_set(bs), .busy_addr(ba), .busy_vec(bv_a), .ready(rdy_a));

  register_file_mp #(.DataLength(DL), .NumRegs(NR), .AddrWidth(AW), .NumReadPorts(NP),
                     .ZeroReg(0), .Bypass(0)) dut_b (
    .clk(clk), .rst(rst), .readreg_addr(raddr), .read_data(rd_b),
    .writereg_addr0(wa0), .write_data0(wd0), .RegWrite0(we0),
    .writereg_addr1(wa1), .write_data1(wd1), .RegWrite1(we1),
    .busy_set(bs), .busy_addr(ba), .busy_vec(bv_b), .ready(rdy_b));

  // Reference model: index 0 models dut_a, index 1 models dut_b.
  logic [DL-1:0] m_regs [2][NR];
  logic [NR-1:0] m_busy [2];
  int            m_edges;
  bit            m_ready;
  int            compared   = 0;
  int            mismatched = 0;

  function automatic bit zr(int k);
    return (k == 0);
  endfunction

  function automatic bit byp(int k);
    return (k == 0);
  endfunction

  function automatic logic [DL-1:0] exp_read(int k, logic [AW-1:0] a);
    if (!m_ready) return 64'd0;
    if (zr(k) && a == 6'd0) return 64'd0;
    if (byp(k) && we1 && wa1 == a) return wd1;
    if (byp(k) && we0 && wa0 == a) return wd0;
    return m_regs[k][a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_edges = 0;
      m_ready = 1'b0;
      for (int k = 0; k < 2; k++) m_busy[k] = '0;
    end else if (!m_ready) begin
      m_edges++;
      if (m_edges == NR) begin
        m_ready = 1'b1;
        for (int k = 0; k < 2; k++)
          for (int r = 0; r < NR; r++) m_regs[k][r] = 64'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we0 && !(zr(k) && wa0 == 6'd0)) m_regs[k][wa0] = wd0;
        if (we1 && !(zr(k) && wa1 == 6'd0)) m_regs[k][wa1] = wd1;
        if (we0) m_busy[k][wa0] = 1'b0;
        if (we1) m_busy[k][wa1] = 1'b0;
        if (bs)  m_busy[k][ba]  = 1'b1;
        if (zr(k)) m_busy[k][0] = 1'b0;
      end
    end
  endtask

  task automatic check(string tag, logic [DL-1:0] obs, logic [DL-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check reads before the edge, update the model, check registered outputs after.
  task automatic step();
    logic [DL-1:0] obs;
    #1;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) begin
        obs = (k == 0) ? rd_a[p*DL +: DL] : rd_b[p*DL +: DL];
        check($sformatf("read_i%0d_p%0d_t%0t", k, p, $time), obs, exp_read(k, raddr[p*AW +: AW]));
      end
    @(posedge clk);
    model_edge();
    #1;
    check("ready_a", {63'd0, rdy_a}, {63'd0, m_ready});
    check("ready_b", {63'd0, rdy_b}, {63'd0, m_ready});
    check("busy_a", bv_a, m_busy[0]);
    check("busy_b", bv_b, m_busy[1]);
  endtask

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; bs = 1'b0;
  endtask

  task automatic rand_inputs(bit narrow);
    int hi;
    hi  = narrow ? 15 : 63;
    wa0 = AW'($urandom_range(0, hi));
    wa1 = AW'($urandom_range(0, hi));
    ba  = AW'($urandom_range(0, hi));
    for (int p = 0; p < NP; p++) raddr[p*AW +: AW] = AW'($urandom_range(0, hi));
    wd0 = {$urandom, $urandom};
    wd1 = {$urandom, $urandom};
    we0 = 1'($urandom_range(0, 1));
    we1 = 1'($urandom_range(0, 1));
    bs  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    m_edges = 0;
    m_ready = 1'b0;
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0; bs = 1'b0;
    wa0 = '0; wa1 = '0; ba = '0; wd0 = '0; wd1 = '0; raddr = '0;

    // 1. Reset clear, with write/busy traffic that must be ignored during the clear.
    step(); step();
    for (int i = 0; i < NR; i++) begin
      rand_inputs(1'b0);
      rst = 1'b0;
      step();
      check("ready_edge", {63'd0, rdy_a}, (i == NR - 1) ? 64'd1 : 64'd0);
    end
    check("busy_after_clear", bv_a, 64'd0);

    // Fill with random traffic so garbage exists before the next reset.
    for (int i = 0; i < 150; i++) begin
      rand_inputs(i < 75);
      step();
    end

    // 2. Reset mid-clear at count 30, then a full clear.
    idle(); rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin rand_inputs(1'b0); rst = 1'b0; step(); end
    idle(); rst = 1'b1; step();
    for (int i = 0; i < NR; i++) begin
      rand_inputs(1'b0);
      rst = 1'b0;
      step();
      check("ready_edge2", {63'd0, rdy_a}, (i == NR - 1) ? 64'd1 : 64'd0);
    end
    idle();
    for (int i = 0; i < NR / NP; i++) begin
      raddr = {AW'(2 * i + 1), AW'(2 * i)};
      step();
      check("sweep_zero_a", rd_a, 128'd0);
      check("sweep_zero_b", rd_b, 128'd0);
    end

    // 3. Write 5 <= DEADBEEF: bypassed in dut_a, old value in dut_b, both visible next cycle.
    idle(); we0 = 1'b1; wa0 = 6'd5; wd0 = 64'hDEAD_BEEF; raddr = {6'd1, 6'd5};
    #1;
    check("byp_same_a", rd_a[0 +: DL], 64'hDEAD_BEEF);
    check("nobyp_same_b", rd_b[0 +: DL], 64'd0);
    step();
    idle();
    #1;
    check("persist_a", rd_a[0 +: DL], 64'hDEAD_BEEF);
    check("persist_b", rd_b[0 +: DL], 64'hDEAD_BEEF);
    step();

    // 4. Dual-write collision on register 9: port 1 wins.
    we0 = 1'b1; wa0 = 6'd9; wd0 = 64'h11; we1 = 1'b1; wa1 = 6'd9; wd1 = 64'h22;
    raddr = {6'd9, 6'd9};
    #1;
    check("collide_byp_a", rd_a[DL +: DL], 64'h22);
    step();
    idle();
    #1;
    check("collide_a", rd_a[0 +: DL], 64'h22);
    check("collide_b", rd_b[0 +: DL], 64'h22);
    step();

    // 5. Zero register: write then busy_set on address 0.
    we0 = 1'b1; wa0 = 6'd0; wd0 = 64'hFFFF; raddr = {6'd0, 6'd0};
    step();
    idle(); bs = 1'b1; ba = 6'd0;
    #1;
    check("zero_read_a", rd_a[0 +: DL], 64'd0);
    check("zero_read_b", rd_b[0 +: DL], 64'hFFFF);
    step();
    idle();
    check("zero_busy_a", {63'd0, bv_a[0]}, 64'd0);
    check("zero_busy_b", {63'd0, bv_b[0]}, 64'd1);

    // 6. Scoreboard on register 12.
    bs = 1'b1; ba = 6'd12;
    step();
    check("sb_set", {63'd0, bv_a[12]}, 64'd1);
    we1 = 1'b1; wa1 = 6'd12; wd1 = 64'h1234; bs = 1'b1; ba = 6'd12;
    step();
    check("sb_set_wins", {63'd0, bv_a[12]}, 64'd1);
    idle(); we0 = 1'b1; wa0 = 6'd12; wd0 = 64'h5678;
    step();
    check("sb_clear", {63'd0, bv_a[12]}, 64'd0);

    // More random traffic in RUN.
    for (int i = 0; i < 200; i++) begin
      rand_inputs(i % 2 == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
